neopixel_rx: RTL
================

Name: neopixel_rx

Overview:
- Single-wire NeoPixel (WS2812-style) stream decoder; receiving end of the `neopixel` transmitter.
- Measures high-pulse widths on `din` and assembles 24-bit pixel words, MSB first, in transmitted GRB order.
- Flags frame end on the latch (reset) gap and forwards the stream after the first word, as a real pixel does.
- Used as a pixel-chain model in benches and as a loopback checker on the board.

Parameters:
- BIT_THRESH, 10: high-time cycles at or above which a bit decodes as 1 (T0H ≈ 6, T1H ≈ 13 cycles at 16 MHz).
- MIN_HIGH, 2: high pulses shorter than this are glitches and are discarded.
- MAX_HIGH, 30: high time reaching this count is a stuck-high error.
- RESET_CYCLES, 800: continuous low cycles that end a frame (50 µs at 16 MHz).
- IDX_W, 8: width of the pixel index.

Ports:
- clk_16MHz  in  1  16 MHz system clock.
- rst  in  1  asynchronous, active-high reset.
- din  in  1  asynchronous serial NeoPixel input.
- dout  out  1  forwarded stream for the next pixel.
- pixel_data  out  24  last decoded word; first-received bit at [23].
- pixel_valid  out  1  one-cycle strobe when pixel_data and pixel_index update.
- pixel_index  out  IDX_W  position of the word in the current frame, 0-based.
- frame_done  out  1  one-cycle strobe when the latch gap is detected.
- bit_error  out  1  one-cycle strobe on a protocol error.

Behaviour:
- Reset values: all outputs 0; internal counters 0; forwarding off; state WAIT_GAP.
- Input synchronisation:
  - `din` passes through a 2-FF synchroniser to give `din_s`; `din_d` is the previous `din_s`.
  - Edges are detected combinationally from `din_s` and `din_d`.
  - All outputs are registered.
- State WAIT_GAP:
  - `lo_cnt` counts cycles with `din_s`=0 and clears whenever `din_s`=1.
  - When `lo_cnt` reaches RESET_CYCLES, go to IDLE. No frame_done is issued.
- State IDLE:
  - A rising edge goes to HIGH with `hi_cnt`=1.
- State HIGH:
  - `hi_cnt` increments each cycle.
  - If `hi_cnt` reaches MAX_HIGH: pulse bit_error, clear `bit_cnt`/`word_cnt`, turn forwarding off, go to WAIT_GAP.
  - On a falling edge with `hi_cnt` < MIN_HIGH: discard the pulse (no shift) and go to LOW.
  - On any other falling edge:
    - Shift in bit = (`hi_cnt` ≥ BIT_THRESH), increment `bit_cnt`, go to LOW with `lo_cnt`=1.
    - If that was the 24th bit: load pixel_data with the 24 bits, pulse pixel_valid, and drive pixel_index = `word_cnt`.
    - Then set `bit_cnt`=0 and increment `word_cnt`, saturating at 2^IDX_W−1 (further words reuse the max index).
    - If `word_cnt` was 0, turn forwarding on.
- State LOW:
  - `lo_cnt` increments each cycle.
  - A rising edge goes to HIGH with `hi_cnt`=1.
  - When `lo_cnt` reaches RESET_CYCLES:
    - Pulse frame_done.
    - Also pulse bit_error in the same cycle if `bit_cnt` ≠ 0; the partial word is dropped and pixel_data is unchanged.
    - Clear `bit_cnt`/`word_cnt`, turn forwarding off, go to IDLE.
- Latency: pixel_valid asserts on the 3rd rising clk_16MHz edge after the `din` falling edge that ends the 24th bit. frame_done follows the same 3-edge rule, counted from RESET_CYCLES of synchronised low.
- Forwarding:
  - While forwarding is on, dout = `din_s` registered (din delayed 3 edges), glitches included.
  - Otherwise dout = 0. The first word is therefore never forwarded.
- No output strobes are issued while in WAIT_GAP.
- Reset asserted mid-frame aborts immediately (no strobes) and returns to WAIT_GAP.
- Counter widths are sized to hold RESET_CYCLES and MAX_HIGH without wrap.

Test Plan:
- Startup and single word:
  - Stimulus: rst, then `din` low for 800 cycles, then send word 0x00_64_00 with T0H=6/T0L=14 and T1H=13/T1L=7 cycles, then 800 cycles low.
  - Required: one pixel_valid with pixel_data=0x006400 and pixel_index=0, 3 edges after the last fall; frame_done once; dout stays 0 throughout.
- Three-word frame:
  - Stimulus: send 0x640000, 0x000064, 0xFFFFFF, then the gap.
  - Required: pixel_index 0, 1, 2 with matching data; dout reproduces words 2–3 bit-exact (high times preserved, 3-cycle delay); frame_done once.
- Partial frame and glitch:
  - Stimulus: send 10 bits, then the gap; separately insert a 1-cycle high pulse mid-word.
  - Required: partial frame gives bit_error and frame_done in the same cycle with no pixel_valid; the glitch is ignored and the following word still decodes correctly.
- Stuck high:
  - Stimulus: hold `din` high for 40 cycles mid-word.
  - Required: bit_error at `hi_cnt`=30; no frame_done; decoding resumes only after 800 low cycles.
- Asynchronous reset and saturation:
  - Stimulus: assert rst during word 1; separately, with IDX_W=2, send 6 words.
  - Required: rst gives immediate zero outputs and no strobes until after the gap; saturation case gives pixel_index 0, 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/neopixel_rx.sv
// WS2812 stream decoder: pulse-width bit slicing into 24-bit GRB words; strobes 3 clk edges after the causing din edge.
// No backpressure: pixel_valid/frame_done/bit_error are single-cycle strobes; every word after the first is forwarded on dout.
module neopixel_rx #(
  parameter int BIT_THRESH   = 10,
  parameter int MIN_HIGH     = 2,
  parameter int MAX_HIGH     = 30,
  parameter int RESET_CYCLES = 800,
  parameter int IDX_W        = 8
) (
  input  logic             clk_16MHz,
  input  logic             rst,
  input  logic             din,
  output logic             dout,
  output logic [23:0]      pixel_data,
  output logic             pixel_valid,
  output logic [IDX_W-1:0] pixel_index,
  output logic             frame_done,
  output logic             bit_error
);

  localparam int LO_W = $clog2(RESET_CYCLES + 1);
  localparam int HI_W = $clog2(MAX_HIGH + 1);
  localparam logic [LO_W-1:0]  LO_END  = LO_W'(RESET_CYCLES);
  localparam logic [HI_W-1:0]  HI_END  = HI_W'(MAX_HIGH);
  localparam logic [HI_W-1:0]  HI_MIN  = HI_W'(MIN_HIGH);
  localparam logic [HI_W-1:0]  HI_ONE  = HI_W'(BIT_THRESH);
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH, LOW} state_t;

  logic din_m, din_s, din_d;
  logic rise, fall, new_bit;

  state_t           state, state_nx;
  logic [LO_W-1:0]  lo_cnt, lo_nx;
  logic [HI_W-1:0]  hi_cnt, hi_nx;
  logic [4:0]       bit_cnt, bit_nx;
  logic [IDX_W-1:0] word_cnt, word_nx;
  logic [22:0]      shreg, sh_nx;
  logic             fwd, fwd_nx;
  logic [23:0]      data_nx;
  logic [IDX_W-1:0] index_nx;
  logic             valid_nx, done_nx, err_nx, dout_nx;

  always_ff @(posedge clk_16MHz or posedge rst) begin
    if (rst) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
      din_d <= din_s;
    end
  end

  assign rise    = din_s & ~din_d;
  assign fall    = ~din_s & din_d;
  assign new_bit = (hi_cnt >= HI_ONE);

  always_comb begin
    state_nx = state;
    lo_nx    = lo_cnt;
    hi_nx    = hi_cnt;
    bit_nx   = bit_cnt;
    word_nx  = word_cnt;
    sh_nx    = shreg;
    fwd_nx   = fwd;
    data_nx  = pixel_data;
    index_nx = pixel_index;
    valid_nx = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    dout_nx  = fwd & din_s;
    case (state)
      WAIT_GAP: begin
        if (din_s) begin
          lo_nx = '0;
        end else if (lo_cnt == LO_END) begin
          lo_nx    = '0;
          state_nx = IDLE;
        end else begin
          lo_nx = lo_cnt + 1'b1;
        end
      end
      IDLE: begin
        if (rise) begin
          hi_nx    = HI_W'(1);
          state_nx = HIGH;
        end
      end
      HIGH: begin
        if (hi_cnt == HI_END) begin
          err_nx   = 1'b1;
          bit_nx   = '0;
          word_nx  = '0;
          fwd_nx   = 1'b0;
          lo_nx    = '0;
          state_nx = WAIT_GAP;
        end else if (fall) begin
          state_nx = LOW;
          // Glitches leave the bit count and the gap timer untouched.
          if (hi_cnt >= HI_MIN) begin
            lo_nx  = LO_W'(1);
            sh_nx  = {shreg[21:0], new_bit};
            bit_nx = bit_cnt + 1'b1;
            if (bit_cnt == 5'd23) begin
              data_nx  = {shreg, new_bit};
              valid_nx = 1'b1;
              index_nx = word_cnt;
              bit_nx   = '0;
              if (word_cnt != IDX_MAX) word_nx = word_cnt + 1'b1;
              if (word_cnt == '0)      fwd_nx  = 1'b1;
            end
          end
        end else begin
          hi_nx = hi_cnt + 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          hi_nx    = HI_W'(1);
          state_nx = HIGH;
        end else if (lo_cnt == LO_END) begin
          done_nx  = 1'b1;
          err_nx   = (bit_cnt != 5'd0);
          bit_nx   = '0;
          word_nx  = '0;
          fwd_nx   = 1'b0;
          lo_nx    = '0;
          state_nx = IDLE;
        end else begin
          lo_nx = lo_cnt + 1'b1;
        end
      end
      default: state_nx = WAIT_GAP;
    endcase
  end

  always_ff @(posedge clk_16MHz or posedge rst) begin
    if (rst) begin
      state       <= WAIT_GAP;
      lo_cnt      <= '0;
      hi_cnt      <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      shreg       <= '0;
      fwd         <= 1'b0;
      dout        <= 1'b0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
    end else begin
      state       <= state_nx;
      lo_cnt      <= lo_nx;
      hi_cnt      <= hi_nx;
      bit_cnt     <= bit_nx;
      word_cnt    <= word_nx;
      shreg       <= sh_nx;
      fwd         <= fwd_nx;
      dout        <= dout_nx;
      pixel_data  <= data_nx;
      pixel_valid <= valid_nx;
      pixel_index <= index_nx;
      frame_done  <= done_nx;
      bit_error   <= err_nx;
    end
  end

endmodule
